// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, the checker state type and the 32-bit word update
// used by both the transmit-side generator and this receive-side checker.
package crc_pkg;

  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } chk_state_e;

  // MSB-first, non-reflected update: data bit 31 enters the register first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 next-state over one 32-bit data word.
module crc32_word_update
  import crc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [31:0] data,
  output logic [31:0] next
);

  assign next = crc32_word(crc, data);

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side frame checker: strips the trailing FCS word, forwards payload
// through a hold/output register pair and reports CRC status per frame.
module crc32_frame_checker
  import crc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             stat_valid,
  output logic             stat_crc_ok,
  output logic             stat_runt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output chk_state_e       fsm_state
);

  // Handshake: a word moves on a port in every cycle where valid && ready are
  // both high at the rising edge; valid never waits on ready, and s_ready is
  // built only from registers and m_ready.

  chk_state_e  state;
  logic [31:0] h_reg;
  logic [31:0] o_reg;
  logic        o_v;
  logic        o_last;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic        h_v;
  logic        accept;
  logic        fcs_match;

  assign h_v       = (state == ST_BODY);
  assign s_ready   = !h_v || !o_v || m_ready;
  assign accept    = s_valid && s_ready;
  assign fcs_match = (s_data == crc_next);

  assign m_valid   = o_v;
  assign m_data    = o_reg;
  assign m_last    = o_last;
  assign fsm_state = state;

  crc32_word_update u_update (
    .crc  (crc_reg),
    .data (h_reg),
    .next (crc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      h_reg       <= '0;
      o_reg       <= '0;
      o_v         <= 1'b0;
      o_last      <= 1'b0;
      crc_reg     <= CRC32_INIT;
      stat_valid  <= 1'b0;
      stat_crc_ok <= 1'b0;
      stat_runt   <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (o_v && m_ready) o_v <= 1'b0;

      if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (s_last) begin
              // FCS with no payload in front of it: a runt, always bad.
              stat_valid  <= 1'b1;
              stat_crc_ok <= 1'b0;
              stat_runt   <= 1'b1;
              crc_reg     <= CRC32_INIT;
              if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
            end else begin
              h_reg <= s_data;
              state <= ST_BODY;
            end
          end
          ST_BODY: begin
            o_reg  <= h_reg;
            o_last <= s_last;
            o_v    <= 1'b1;
            if (s_last) begin
              state       <= ST_IDLE;
              crc_reg     <= CRC32_INIT;
              stat_valid  <= 1'b1;
              stat_crc_ok <= fcs_match;
              stat_runt   <= 1'b0;
              if (fcs_match) begin
                if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
              end else begin
                if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
              end
            end else begin
              h_reg   <= s_data;
              crc_reg <= crc_next;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker: frames are scored against a
// long-division CRC model; a second instance with CNT_W=2 checks saturation.
module tb_crc32_frame_checker;
  import crc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_ready = 1'b1;
  logic        s_ready, m_valid, m_last, stat_valid, stat_crc_ok, stat_runt;
  logic [31:0] m_data;
  logic [15:0] good_cnt, bad_cnt;
  chk_state_e  fsm_state;

  logic        d2_s_ready, d2_m_valid, d2_m_last, d2_stat_valid, d2_stat_crc_ok, d2_stat_runt;
  logic [31:0] d2_m_data;
  logic [1:0]  d2_good_cnt, d2_bad_cnt;
  chk_state_e  d2_fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_good = 0;
  int exp_bad  = 0;
  int rdy_mode = 0;
  bit ignore_mon = 1'b1;
  int stall_viol = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [1:0]  exp_st[$];
  logic [1:0]  obs_st[$];

  crc32_frame_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .stat_valid(stat_valid),
    .stat_crc_ok(stat_crc_ok), .stat_runt(stat_runt), .good_cnt(good_cnt),
    .bad_cnt(bad_cnt), .fsm_state(fsm_state)
  );

  crc32_frame_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(d2_s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(d2_m_valid), .m_ready(m_ready),
    .m_data(d2_m_data), .m_last(d2_m_last), .stat_valid(d2_stat_valid),
    .stat_crc_ok(d2_stat_crc_ok), .stat_runt(d2_stat_runt), .good_cnt(d2_good_cnt),
    .bad_cnt(d2_bad_cnt), .fsm_state(d2_fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: records observed handshakes and stall stability on the falling edge
  logic        stall_prev = 1'b0;
  logic [31:0] st_data = '0;
  logic        st_last = 1'b0;
  always @(negedge clk) begin
    if (ignore_mon) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && (!m_valid || m_data !== st_data || m_last !== st_last))
        stall_viol <= stall_viol + 1;
      if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
      if (stat_valid) obs_st.push_back({stat_crc_ok, stat_runt});
      stall_prev <= m_valid && !m_ready;
      st_data    <= m_data;
      st_last    <= m_last;
    end
  end

  // reference CRC: augmented long division with init folded into the first 32 bits
  function automatic logic [31:0] model_crc(input logic [31:0] pl[$]);
    bit          bits[$];
    logic [31:0] rem;
    bit          top;
    foreach (pl[w]) for (int b = 31; b >= 0; b--) bits.push_back(pl[w][b]);
    for (int i = 0; i < 32; i++) bits[i] = ~bits[i];
    for (int i = 0; i < 32; i++) bits.push_back(1'b0);
    rem = '0;
    foreach (bits[i]) begin
      top = rem[31];
      rem = {rem[30:0], bits[i]};
      if (top) rem = rem ^ 32'h04C11DB7;
    end
    return rem;
  endfunction

  // driver tasks
  task automatic push_word(input logic [31:0] d, input logic l);
    bit acc;
    int n;
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_frame(input logic [31:0] pl[$], input bit flip);
    logic [31:0] fcs;
    fcs = model_crc(pl) ^ {31'b0, flip};
    foreach (pl[i]) exp_q.push_back({1'(i == pl.size() - 1), pl[i]});
    exp_st.push_back({~flip, 1'b0});
    if (flip) exp_bad++; else exp_good++;
    foreach (pl[i]) push_word(pl[i], 1'b0);
    push_word(fcs, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic send_runt(input logic [31:0] d);
    exp_st.push_back(2'b01);
    exp_bad++;
    push_word(d, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic apply_reset();
    ignore_mon = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); exp_st.delete(); obs_st.delete();
    exp_good = 0; exp_bad = 0;
    ignore_mon = 1'b0;
  endtask

  task automatic wait_drain(output bit to);
    int k = 0;
    while ((obs_q.size() < exp_q.size() || obs_st.size() < exp_st.size()) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    to = (k >= 2000);
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_stat_valid: got %b want 0", stat_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    n_checks++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", good_cnt, bad_cnt); end
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
  endtask

  task automatic test_good_frame(input bit flip, input string tag);
    logic [31:0] pl[$];
    bit to;
    apply_reset();
    rdy_mode = 0;
    pl = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_frame(pl, flip);
    wait_drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s drain: timeout, got %0d words want %0d", tag, obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL %s word_count: got %0d want 3", tag, obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s word%0d: got %h want %h", tag, i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (obs_st.size() != 1 || obs_st[0] !== {~flip, 1'b0}) begin n_fail++; $display("FAIL %s status: got %0d pulses first=%b want 1 pulse %b", tag, obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 2'bxx, {~flip, 1'b0}); end
    n_checks++; if (good_cnt !== 16'(!flip) || bad_cnt !== 16'(flip)) begin n_fail++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", tag, good_cnt, bad_cnt, !flip, flip); end
  endtask

  task automatic test_runt();
    bit to;
    apply_reset();
    rdy_mode = 0;
    send_runt(32'hDEADBEEF);
    wait_drain(to);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL runt_no_output: got %0d words want 0", obs_q.size()); end
    n_checks++; if (obs_st.size() != 1 || obs_st[0] !== 2'b01) begin n_fail++; $display("FAIL runt_status: got %0d pulses first=%b want 1 pulse 01", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 2'bxx); end
    n_checks++; if (bad_cnt !== 16'd1 || good_cnt !== 16'd0) begin n_fail++; $display("FAIL runt_counters: got %0d/%0d want 0/1", good_cnt, bad_cnt); end
  endtask

  task automatic run_and_score(input string tag, input int n_frames, input int mode, input bit allow_bad);
    logic [31:0] pl[$];
    bit to;
    int v0;
    apply_reset();
    rdy_mode = mode;
    v0 = stall_viol;
    for (int f = 0; f < n_frames; f++) begin
      if (allow_bad && $urandom_range(0, 5) == 0) begin
        send_runt($urandom());
      end else begin
        pl.delete();
        repeat (allow_bad ? $urandom_range(1, 5) : 3) pl.push_back($urandom());
        send_frame(pl, allow_bad && ($urandom_range(0, 2) == 0));
      end
      if (allow_bad) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s drain: timeout, got %0d words want %0d", tag, obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %s word_count: got %0d want %0d", tag, obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s word%0d: got %h want %h", tag, i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL %s pulse_count: got %0d want %0d", tag, obs_st.size(), exp_st.size()); end
    foreach (exp_st[i]) if (i < obs_st.size()) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i]) begin n_fail++; $display("FAIL %s status%0d: got %b want %b", tag, i, obs_st[i], exp_st[i]); end
    end
    n_checks++; if (stall_viol != v0) begin n_fail++; $display("FAIL %s stall_stable: got %0d changes want 0", tag, stall_viol - v0); end
    n_checks++; if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin n_fail++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", tag, good_cnt, bad_cnt, exp_good, exp_bad); end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    run_and_score("back_to_back", 2, 1, 1'b0);
    n_checks++; if (good_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_good_cnt: got %0d want 2", good_cnt); end
  endtask

  task automatic test_random();
    run_and_score("random", 10, 2, 1'b1);
  endtask

  task automatic test_abort();
    logic [31:0] pl[$];
    bit to;
    apply_reset();
    rdy_mode = 0;
    ignore_mon = 1'b1;
    push_word($urandom(), 1'b0);
    push_word($urandom(), 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete(); obs_st.delete();
    ignore_mon = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (obs_st.size() != 0) begin n_fail++; $display("FAIL abort_no_status: got %0d pulses want 0", obs_st.size()); end
    n_checks++; if (fsm_state !== ST_IDLE || m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_cleared: got state=%0d m_valid=%b want 0/0", fsm_state, m_valid); end
    pl = '{$urandom(), $urandom(), $urandom(), $urandom()};
    send_frame(pl, 1'b0);
    wait_drain(to);
    n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL abort_clean_words: got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (obs_st.size() != 1 || obs_st[0] !== 2'b10) begin n_fail++; $display("FAIL abort_clean_status: got %0d pulses first=%b want 1 pulse 10", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 2'bxx); end
    n_checks++; if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin n_fail++; $display("FAIL abort_counters: got %0d/%0d want 1/0", good_cnt, bad_cnt); end
  endtask

  task automatic test_saturate();
    logic [31:0] pl[$];
    bit to;
    int want2;
    apply_reset();
    rdy_mode = 0;
    for (int f = 0; f < 5; f++) begin
      pl = '{$urandom(), $urandom()};
      send_frame(pl, 1'b1);
      wait_drain(to);
      want2 = (f + 1 > 3) ? 3 : f + 1;
      n_checks++; if (d2_bad_cnt !== 2'(want2)) begin n_fail++; $display("FAIL sat_bad_cnt%0d: got %0d want %0d", f, d2_bad_cnt, want2); end
      n_checks++; if (bad_cnt !== 16'(f + 1)) begin n_fail++; $display("FAIL wide_bad_cnt%0d: got %0d want %0d", f, bad_cnt, f + 1); end
    end
    n_checks++; if (d2_good_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_good_cnt: got %0d want 0", d2_good_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    test_reset();
    test_good_frame(1'b0, "good_frame");
    test_good_frame(1'b1, "bad_fcs");
    test_runt();
    test_back_to_back();
    test_random();
    test_abort();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
